// File: rtl/control_multicycle.sv
// Multicycle control unit for the accumulator datapath. A CLR/FETCH/EXECUTE/HALT FSM
// with a wait-stated fetch handshake, a CALL/RET return stack and a sticky stack-error flag.
module control_multicycle #(
  parameter int OPERAND_WIDTH     = 11,
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int STACK_DEPTH       = 4
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
  input  logic                         instruction_valid_in,
  input  logic                         status_Z_in,
  input  logic                         status_N_in,
  output logic [OPERAND_WIDTH-1:0]     instruction_address_out,
  output logic                         instruction_req_out,
  output logic [OPERAND_WIDTH-1:0]     operand_out,
  output logic [1:0]                   sel_A_out,
  output logic                         sel_B_out,
  output logic                         alu_op_out,
  output logic                         data_memory_wr_out,
  output logic                         acc_wr_out,
  output logic                         status_wr_out,
  output logic                         acc_reset_out,
  output logic                         status_reset_out,
  output logic                         halted_out,
  output logic                         stack_error_out
);

  localparam int OW    = OPERAND_WIDTH;
  localparam int OPC_W = INSTRUCTION_WIDTH - OPERAND_WIDTH;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(8'h00);
  localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(8'h01);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(8'h02);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(8'h03);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(8'h04);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(8'h05);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(8'h06);
  localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(8'h07);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(8'h08);
  localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(8'h09);
  localparam logic [OPC_W-1:0] OP_BGT  = OPC_W'(8'h0A);
  localparam logic [OPC_W-1:0] OP_BGE  = OPC_W'(8'h0B);
  localparam logic [OPC_W-1:0] OP_BLT  = OPC_W'(8'h0C);
  localparam logic [OPC_W-1:0] OP_BLE  = OPC_W'(8'h0D);
  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(8'h0E);
  localparam logic [OPC_W-1:0] OP_CALL = OPC_W'(8'h0F);
  localparam logic [OPC_W-1:0] OP_RET  = OPC_W'(8'h10);

  typedef enum logic [1:0] {S_CLR, S_FETCH, S_EXECUTE, S_HALT} state_t;

  state_t                       state, state_next;
  logic [OW-1:0]                pc, pc_next, pc_plus1;
  logic [INSTRUCTION_WIDTH-1:0] ir;
  logic [SP_W-1:0]              sp;
  logic                         ir_load, push, pop, err_set;
  logic                         stack_full, stack_empty;
  logic [IDX_W-1:0]             push_idx, top_idx;
  logic [OW-1:0]                stack_mem [2**IDX_W];
  logic [OPC_W-1:0]             opcode;
  logic [OW-1:0]                operand;

  assign opcode      = ir[INSTRUCTION_WIDTH-1:OW];
  assign operand     = ir[OW-1:0];
  assign pc_plus1    = pc + OW'(1);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign push_idx    = IDX_W'(sp);
  assign top_idx     = IDX_W'(sp - SP_W'(1));

  assign instruction_address_out = pc;
  assign operand_out             = operand;
  assign halted_out              = (state == S_HALT);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_next          = state;
    pc_next             = pc;
    ir_load             = 1'b0;
    push                = 1'b0;
    pop                 = 1'b0;
    err_set             = 1'b0;
    instruction_req_out = 1'b0;
    sel_A_out           = 2'b00;
    sel_B_out           = 1'b0;
    alu_op_out          = 1'b0;
    data_memory_wr_out  = 1'b0;
    acc_wr_out          = 1'b0;
    status_wr_out       = 1'b0;
    acc_reset_out       = 1'b0;
    status_reset_out    = 1'b0;

    case (state)
      S_CLR: begin
        acc_reset_out    = 1'b1;
        status_reset_out = 1'b1;
        state_next       = S_FETCH;
      end
      S_FETCH: begin
        instruction_req_out = 1'b1;
        if (instruction_valid_in) begin
          ir_load    = 1'b1;
          state_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_next = S_FETCH;
        pc_next    = pc_plus1;
        case (opcode)
          OP_HLT: begin
            state_next = S_HALT;
            pc_next    = pc;
          end
          OP_STO: data_memory_wr_out = 1'b1;
          OP_LD:  acc_wr_out = 1'b1;
          OP_LDI: begin
            sel_A_out  = 2'b01;
            acc_wr_out = 1'b1;
          end
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
            sel_A_out     = 2'b10;
            sel_B_out     = opcode[0];
            alu_op_out    = opcode[1];
            acc_wr_out    = 1'b1;
            status_wr_out = 1'b1;
          end
          OP_BEQ: if (status_Z_in) pc_next = operand;
          OP_BNE: if (!status_Z_in) pc_next = operand;
          OP_BGT: if (!status_Z_in && !status_N_in) pc_next = operand;
          OP_BGE: if (!status_N_in) pc_next = operand;
          OP_BLT: if (status_N_in) pc_next = operand;
          OP_BLE: if (status_N_in || status_Z_in) pc_next = operand;
          OP_JMP: pc_next = operand;
          OP_CALL: begin
            if (stack_full) begin
              err_set    = 1'b1;
              state_next = S_HALT;
              pc_next    = pc;
            end else begin
              push    = 1'b1;
              pc_next = operand;
            end
          end
          OP_RET: begin
            if (stack_empty) begin
              err_set    = 1'b1;
              state_next = S_HALT;
              pc_next    = pc;
            end else begin
              pop     = 1'b1;
              pc_next = stack_mem[top_idx];
            end
          end
          default: ;
        endcase
      end
      S_HALT: ;
      default: state_next = S_CLR;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset_in) begin
      state           <= S_CLR;
      pc              <= '0;
      ir              <= '0;
      sp              <= '0;
      stack_error_out <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (ir_load) ir <= instruction_in;
      if (push)     sp <= sp + SP_W'(1);
      else if (pop) sp <= sp - SP_W'(1);
      if (err_set)  stack_error_out <= 1'b1;
    end
  end

  // NOTE: stack storage has no reset; sp gates every read, so stale entries are never seen.
  always_ff @(posedge clock_in) begin
    if (push) stack_mem[push_idx] <= pc_plus1;
  end

endmodule

// File: tb/tb_control_multicycle.sv
// Directed self-checking bench for control_multicycle: one task per scenario, with the
// instruction memory modelled as a bench array addressed by the program counter.
module tb_control_multicycle;

  localparam int OW = 11;
  localparam int IW = 16;

  localparam logic [6:0] ST_NONE = 7'b00_0_0_0_0_0;
  localparam logic [6:0] ST_LDI  = 7'b01_0_0_0_1_0;
  localparam logic [6:0] ST_ADD  = 7'b10_0_0_0_1_1;
  localparam logic [6:0] ST_STO  = 7'b00_0_0_1_0_0;

  logic          clock_in = 1'b0;
  logic          reset_in = 1'b0;
  logic [IW-1:0] instruction_in;
  logic          instruction_valid_in = 1'b1;
  logic          status_Z_in = 1'b0;
  logic          status_N_in = 1'b0;
  logic [OW-1:0] instruction_address_out;
  logic          instruction_req_out;
  logic [OW-1:0] operand_out;
  logic [1:0]    sel_A_out;
  logic          sel_B_out, alu_op_out, data_memory_wr_out, acc_wr_out, status_wr_out;
  logic          acc_reset_out, status_reset_out, halted_out, stack_error_out;

  logic [IW-1:0] imem [0:2047];
  logic [6:0]    strobes;
  int            checks = 0;
  int            errors = 0;

  control_multicycle #(.OPERAND_WIDTH(OW), .INSTRUCTION_WIDTH(IW), .STACK_DEPTH(4)) dut (
    .clock_in                (clock_in),
    .reset_in                (reset_in),
    .instruction_in          (instruction_in),
    .instruction_valid_in    (instruction_valid_in),
    .status_Z_in             (status_Z_in),
    .status_N_in             (status_N_in),
    .instruction_address_out (instruction_address_out),
    .instruction_req_out     (instruction_req_out),
    .operand_out             (operand_out),
    .sel_A_out               (sel_A_out),
    .sel_B_out               (sel_B_out),
    .alu_op_out              (alu_op_out),
    .data_memory_wr_out      (data_memory_wr_out),
    .acc_wr_out              (acc_wr_out),
    .status_wr_out           (status_wr_out),
    .acc_reset_out           (acc_reset_out),
    .status_reset_out        (status_reset_out),
    .halted_out              (halted_out),
    .stack_error_out         (stack_error_out)
  );

  assign instruction_in = imem[instruction_address_out];
  assign strobes = {sel_A_out, sel_B_out, alu_op_out, data_memory_wr_out, acc_wr_out, status_wr_out};

  always #5 clock_in = ~clock_in;

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  // Unlisted opcode 0x1F acts as a NOP filler.
  task automatic fill();
    for (int i = 0; i < 2048; i++) imem[i] = 16'hF800;
  endtask

  // Leaves the DUT in CLR just after reset release.
  task automatic do_reset();
    reset_in = 1'b0;
    step();
    step();
    reset_in = 1'b1;
  endtask

  // Jumps from address 0 so the DUT sits in FETCH at the target address.
  task automatic goto_pc(input logic [OW-1:0] target);
    imem[0] = {5'h0E, target};
    do_reset();
    step();
    step();
    step();
  endtask

  task automatic test_reset();
    fill();
    reset_in = 1'b0;
    step();
    checks++;
    if ({acc_reset_out, status_reset_out} !== 2'b11) begin
      errors++;
      $display("FAIL reset_clears: got %b expected 11", {acc_reset_out, status_reset_out});
    end
    checks++;
    if ({strobes, instruction_req_out, halted_out, stack_error_out} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0", {strobes, instruction_req_out, halted_out, stack_error_out});
    end
    checks++;
    if ({instruction_address_out, operand_out} !== 22'h0) begin
      errors++;
      $display("FAIL reset_pc_ir: got %h expected 0", {instruction_address_out, operand_out});
    end
  endtask

  task automatic test_basic_program();
    fill();
    imem[0] = 16'h180D;
    imem[1] = 16'h2002;
    imem[2] = 16'h0000;
    instruction_valid_in = 1'b1;
    do_reset();
    checks++;
    if (acc_reset_out !== 1'b1 || instruction_req_out !== 1'b0) begin
      errors++;
      $display("FAIL clr_cycle: got rst=%b req=%b expected rst=1 req=0", acc_reset_out, instruction_req_out);
    end
    step();
    checks++;
    if (instruction_req_out !== 1'b1 || instruction_address_out !== 11'h000 || acc_reset_out !== 1'b0) begin
      errors++;
      $display("FAIL fetch0: got req=%b pc=%h rst=%b expected 1 000 0", instruction_req_out, instruction_address_out, acc_reset_out);
    end
    step();
    checks++;
    if (strobes !== ST_LDI || operand_out !== 11'd13 || instruction_req_out !== 1'b0) begin
      errors++;
      $display("FAIL exec_ldi: got strobes=%b op=%h req=%b expected %b 00d 0", strobes, operand_out, instruction_req_out, ST_LDI);
    end
    step();
    checks++;
    if (instruction_address_out !== 11'h001) begin
      errors++;
      $display("FAIL pc_after_ldi: got %h expected 001", instruction_address_out);
    end
    step();
    checks++;
    if (strobes !== ST_ADD) begin
      errors++;
      $display("FAIL exec_add: got %b expected %b", strobes, ST_ADD);
    end
    step();
    step();
    checks++;
    if (halted_out !== 1'b0 || strobes !== ST_NONE) begin
      errors++;
      $display("FAIL exec_hlt: got halted=%b strobes=%b expected 0 0", halted_out, strobes);
    end
    step();
    step();
    checks++;
    if (halted_out !== 1'b1 || instruction_address_out !== 11'h002 || instruction_req_out !== 1'b0) begin
      errors++;
      $display("FAIL halt_state: got halted=%b pc=%h req=%b expected 1 002 0", halted_out, instruction_address_out, instruction_req_out);
    end
  endtask

  task automatic test_fetch_stall();
    fill();
    imem[5] = 16'h1807;
    instruction_valid_in = 1'b1;
    goto_pc(11'h005);
    instruction_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (instruction_req_out !== 1'b1 || instruction_address_out !== 11'h005 || strobes !== ST_NONE) begin
        errors++;
        $display("FAIL stall_%0d: got req=%b pc=%h strobes=%b expected 1 005 0", i, instruction_req_out, instruction_address_out, strobes);
      end
    end
    instruction_valid_in = 1'b1;
    step();
    checks++;
    if (strobes !== ST_LDI || operand_out !== 11'h007) begin
      errors++;
      $display("FAIL stall_exec: got strobes=%b op=%h expected %b 007", strobes, operand_out, ST_LDI);
    end
    step();
    checks++;
    if (instruction_address_out !== 11'h006) begin
      errors++;
      $display("FAIL stall_next_pc: got %h expected 006", instruction_address_out);
    end
  endtask

  // Flags are wrong during FETCH and correct only in the EXECUTE cycle.
  task automatic branch_case(input logic [IW-1:0] instr, input logic z, input logic n,
                             input logic [OW-1:0] exp_pc, input string name);
    fill();
    imem[4] = instr;
    status_Z_in = ~z;
    status_N_in = ~n;
    goto_pc(11'h004);
    step();
    status_Z_in = z;
    status_N_in = n;
    step();
    checks++;
    if (instruction_address_out !== exp_pc) begin
      errors++;
      $display("FAIL %s: got pc=%h expected %h", name, instruction_address_out, exp_pc);
    end
  endtask

  task automatic test_branches();
    branch_case(16'h4033, 1'b1, 1'b0, 11'h033, "beq_taken");
    branch_case(16'h4033, 1'b0, 1'b0, 11'h005, "beq_not_taken");
    branch_case(16'h6855, 1'b0, 1'b1, 11'h055, "ble_n_taken");
    branch_case(16'h5055, 1'b1, 1'b0, 11'h005, "bgt_z_not_taken");
    branch_case(16'h4833, 1'b0, 1'b0, 11'h033, "bne_taken");
    branch_case(16'h6033, 1'b0, 1'b1, 11'h033, "blt_taken");
    branch_case(16'h5833, 1'b0, 1'b1, 11'h005, "bge_not_taken");
    status_Z_in = 1'b0;
    status_N_in = 1'b0;
  endtask

  task automatic test_call_ret();
    fill();
    imem[7]  = 16'h7820;
    imem[32] = 16'h8000;
    goto_pc(11'h007);
    step();
    step();
    checks++;
    if (instruction_address_out !== 11'h020) begin
      errors++;
      $display("FAIL call_target: got %h expected 020", instruction_address_out);
    end
    step();
    step();
    checks++;
    if (instruction_address_out !== 11'h008 || stack_error_out !== 1'b0) begin
      errors++;
      $display("FAIL ret_target: got pc=%h err=%b expected 008 0", instruction_address_out, stack_error_out);
    end

    // Two nested calls unwind in LIFO order.
    fill();
    imem[0]     = 16'h7810;
    imem[16]    = 16'h7820;
    imem[32]    = 16'h8000;
    imem[17]    = 16'h8000;
    do_reset();
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      step();
    end
    checks++;
    if (instruction_address_out !== 11'h011) begin
      errors++;
      $display("FAIL nested_ret_inner: got %h expected 011", instruction_address_out);
    end
    step();
    step();
    checks++;
    if (instruction_address_out !== 11'h001) begin
      errors++;
      $display("FAIL nested_ret_outer: got %h expected 001", instruction_address_out);
    end

    // Four nested calls fit; the fifth overflows.
    fill();
    imem[0]  = 16'h7810;
    imem[16] = 16'h7820;
    imem[32] = 16'h7830;
    imem[48] = 16'h7840;
    imem[64] = 16'h7850;
    do_reset();
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      step();
    end
    checks++;
    if (instruction_address_out !== 11'h040 || stack_error_out !== 1'b0 || halted_out !== 1'b0) begin
      errors++;
      $display("FAIL depth4_ok: got pc=%h err=%b halted=%b expected 040 0 0", instruction_address_out, stack_error_out, halted_out);
    end
    step();
    step();
    checks++;
    if (stack_error_out !== 1'b1 || halted_out !== 1'b1 || instruction_address_out !== 11'h040) begin
      errors++;
      $display("FAIL overflow: got err=%b halted=%b pc=%h expected 1 1 040", stack_error_out, halted_out, instruction_address_out);
    end
  endtask

  task automatic test_underflow_and_wrap();
    fill();
    imem[0] = 16'h8000;
    do_reset();
    step();
    step();
    step();
    checks++;
    if (stack_error_out !== 1'b1 || halted_out !== 1'b1 || instruction_address_out !== 11'h000) begin
      errors++;
      $display("FAIL underflow: got err=%b halted=%b pc=%h expected 1 1 000", stack_error_out, halted_out, instruction_address_out);
    end
    fill();
    imem[11'h7FF] = 16'h1801;
    goto_pc(11'h7FF);
    checks++;
    if (instruction_address_out !== 11'h7FF || stack_error_out !== 1'b0) begin
      errors++;
      $display("FAIL jmp_top: got pc=%h err=%b expected 7ff 0", instruction_address_out, stack_error_out);
    end
    step();
    step();
    checks++;
    if (instruction_address_out !== 11'h000) begin
      errors++;
      $display("FAIL pc_wrap: got %h expected 000", instruction_address_out);
    end
  endtask

  task automatic test_reset_mid_execute();
    fill();
    imem[5] = 16'h0803;
    goto_pc(11'h005);
    step();
    checks++;
    if (strobes !== ST_STO) begin
      errors++;
      $display("FAIL sto_exec: got %b expected %b", strobes, ST_STO);
    end
    #2 reset_in = 1'b0;
    #1;
    checks++;
    if (data_memory_wr_out !== 1'b0 || instruction_address_out !== 11'h000 ||
        acc_reset_out !== 1'b1 || operand_out !== 11'h000) begin
      errors++;
      $display("FAIL async_reset: got wr=%b pc=%h rst=%b op=%h expected 0 000 1 000",
               data_memory_wr_out, instruction_address_out, acc_reset_out, operand_out);
    end
    step();
    reset_in = 1'b1;

    fill();
    imem[0] = 16'h8000;
    do_reset();
    step();
    step();
    step();
    #2 reset_in = 1'b0;
    #1;
    checks++;
    if (stack_error_out !== 1'b0 || halted_out !== 1'b0) begin
      errors++;
      $display("FAIL error_cleared: got err=%b halted=%b expected 0 0", stack_error_out, halted_out);
    end
    step();
    reset_in = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_program();
    test_fetch_stall();
    test_branches();
    test_call_ret();
    test_underflow_and_wrap();
    test_reset_mid_execute();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
